// File: rtl/alu_issuer.sv
// alu_issuer: one-command-at-a-time ALU (IDLE -> EXEC -> HOLD) with
// valid/ready command and result handshakes and a delivered-result counter.
// Ports: Clock, Reset_b (sync, active-low); cmd_valid/cmd_ready,
//   cmd_func[1:0], cmd_a[3:0], cmd_b[3:0], cmd_acc; res_valid/res_ready,
//   res_data[7:0], res_count[3:0].
// Option: ALU_ISSUER_FEEDBACK_EN adds an accumulator feeding operand B.
module alu_issuer (
   input  logic       Clock,
   input  logic       Reset_b,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_func,
   input  logic [3:0] cmd_a,
   input  logic [3:0] cmd_b,
   input  logic       cmd_acc,
   output logic       res_valid,
   input  logic       res_ready,
   output logic [7:0] res_data,
   output logic [3:0] res_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t      state, state_nx;
   logic        accept, deliver;
   logic [1:0]  func_q;
   logic [3:0]  a_q, b_q, b_sel;
   logic [4:0]  sum;
   logic [7:0]  result;
   logic [7:0]  res_q;
   logic [3:0]  cnt_q;

`ifdef ALU_ISSUER_FEEDBACK_EN
   logic [7:0] acc_q;

   // B is resolved at accept time so EXEC only sees registered operands
   assign b_sel = cmd_acc ? acc_q[3:0] : cmd_b;

   always_ff @(posedge Clock) begin
      if (!Reset_b)
         acc_q <= 8'h00;
      else if (state == EXEC)
         acc_q <= result;
   end
`else
   logic unused_acc;
   assign unused_acc = cmd_acc;
   assign b_sel      = cmd_b;
`endif

   always_ff @(posedge Clock) begin
      if (!Reset_b)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      cmd_ready = 1'b0;
      res_valid = 1'b0;
      accept    = 1'b0;
      deliver   = 1'b0;
      unique case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               accept   = 1'b1;
               state_nx = EXEC;
            end
         end
         EXEC: state_nx = HOLD;
         HOLD: begin
            res_valid = 1'b1;
            if (res_ready) begin
               deliver  = 1'b1;
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   assign sum = {1'b0, a_q} + {1'b0, b_q};

   always_comb begin
      result = 8'h00;
      unique case (func_q)
         2'b00: result = {3'b000, sum};
         2'b01: result = {7'b0, |{a_q, b_q}};
         2'b10: result = {7'b0, &{a_q, b_q}};
         2'b11: result = {a_q, b_q};
         default: result = 8'h00;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (!Reset_b) begin
         func_q <= 2'b00;
         a_q    <= 4'h0;
         b_q    <= 4'h0;
      end else if (accept) begin
         func_q <= cmd_func;
         a_q    <= cmd_a;
         b_q    <= b_sel;
      end
   end

   always_ff @(posedge Clock) begin
      if (!Reset_b) begin
         res_q <= 8'h00;
         cnt_q <= 4'h0;
      end else begin
         if (state == EXEC)
            res_q <= result;
         if (deliver)
            cnt_q <= cnt_q + 4'd1;
      end
   end

   assign res_data  = res_q;
   assign res_count = cnt_q;

endmodule

// File: tb/tb_alu_issuer.sv
// tb_alu_issuer: vector table, directed corner sequences and random
// commands against a behavioural model of alu_issuer.
module tb_alu_issuer;

   logic       Clock = 1'b0;
   logic       Reset_b = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [1:0] cmd_func = 2'b00;
   logic [3:0] cmd_a = 4'h0;
   logic [3:0] cmd_b = 4'h0;
   logic       cmd_acc = 1'b0;
   logic       res_valid;
   logic       res_ready = 1'b0;
   logic [7:0] res_data;
   logic [3:0] res_count;

   int checks = 0;
   int errors = 0;
   int cnt_model = 0;
   int acc_model = 0;

   alu_issuer dut (
      .Clock     (Clock),
      .Reset_b   (Reset_b),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_func  (cmd_func),
      .cmd_a     (cmd_a),
      .cmd_b     (cmd_b),
      .cmd_acc   (cmd_acc),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .res_count (res_count)
   );

   always #5 Clock = ~Clock;

   typedef struct {
      logic [1:0] f;
      logic [3:0] a;
      logic [3:0] b;
      logic [7:0] exp;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   function automatic int ref_res(input int f, input int a, input int b);
      case (f)
         0: return (a + b) % 256;
         1: return ((a != 0) || (b != 0)) ? 1 : 0;
         2: return ((a == 15) && (b == 15)) ? 1 : 0;
         default: return a * 16 + b;
      endcase
   endfunction

   task automatic tick;
      @(posedge Clock);
      #1;
   endtask

   task automatic do_reset;
      Reset_b   = 1'b0;
      cmd_valid = 1'b0;
      res_ready = 1'b0;
      tick();
      tick();
      Reset_b   = 1'b1;
      cnt_model = 0;
      acc_model = 0;
   endtask

   // full command: accept, EXEC, HOLD with stall cycles, deliver
   task automatic op(input logic [1:0] f, input logic [3:0] a,
                     input logic [3:0] b, input logic acc,
                     input int stall, input bit noise,
                     input logic [7:0] exp, input string name);
      chk({name, "_idle_rdy"}, cmd_ready, 1);
      cmd_func  = f;
      cmd_a     = a;
      cmd_b     = b;
      cmd_acc   = acc;
      cmd_valid = 1'b1;
      res_ready = 1'b0;
      tick();
      cmd_valid = noise;
      cmd_a     = 4'($urandom);
      cmd_b     = 4'($urandom);
      cmd_func  = 2'($urandom);
      res_ready = noise ? 1'($urandom) : 1'b0;
      chk({name, "_exec_rdy"}, cmd_ready, 0);
      chk({name, "_exec_vld"}, res_valid, 0);
      tick();
      res_ready = 1'b0;
      chk({name, "_hold_vld"}, res_valid, 1);
      chk(name, res_data, exp);
      for (int i = 0; i < stall; i++) begin
         cmd_valid = noise;
         cmd_a     = 4'($urandom);
         tick();
         chk({name, "_stall_vld"}, res_valid, 1);
         chk({name, "_stall_rdy"}, cmd_ready, 0);
         chk({name, "_stall_data"}, res_data, exp);
      end
      cmd_valid = 1'b0;
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      cnt_model = (cnt_model + 1) % 16;
      acc_model = exp;
      chk({name, "_cnt"}, res_count, cnt_model);
      chk({name, "_back_idle"}, cmd_ready, 1);
      chk({name, "_post_vld"}, res_valid, 0);
      chk({name, "_retain"}, res_data, exp);
   endtask

   vec_t tbl[8];

   initial begin
      logic [7:0] e;
      int         eb;

      tbl[0] = '{2'b00, 4'hF, 4'h1, 8'h10};
      tbl[1] = '{2'b01, 4'h0, 4'h0, 8'h00};
      tbl[2] = '{2'b10, 4'hF, 4'hF, 8'h01};
      tbl[3] = '{2'b11, 4'hA, 4'h5, 8'hA5};
      tbl[4] = '{2'b00, 4'h7, 4'h8, 8'h0F};
      tbl[5] = '{2'b00, 4'hF, 4'hF, 8'h1E};
      tbl[6] = '{2'b01, 4'h1, 4'h0, 8'h01};
      tbl[7] = '{2'b10, 4'hE, 4'hF, 8'h00};

      do_reset();
      chk("rst_rdy", cmd_ready, 1);
      chk("rst_vld", res_valid, 0);
      chk("rst_data", res_data, 0);
      chk("rst_cnt", res_count, 0);

      for (int i = 0; i < 8; i++)
         op(tbl[i].f, tbl[i].a, tbl[i].b, 1'b0, 0, 1'b0, tbl[i].exp,
            $sformatf("vec%0d", i));

      // backpressure with new commands offered throughout HOLD
      op(2'b11, 4'h3, 4'hC, 1'b0, 5, 1'b1, 8'h3C, "bp");

      // reset in EXEC
      cmd_func  = 2'b11;
      cmd_a     = 4'h9;
      cmd_b     = 4'h6;
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      Reset_b   = 1'b0;
      res_ready = 1'b1;
      tick();
      Reset_b   = 1'b1;
      res_ready = 1'b0;
      cnt_model = 0;
      acc_model = 0;
      chk("rexec_rdy", cmd_ready, 1);
      chk("rexec_vld", res_valid, 0);
      chk("rexec_data", res_data, 0);
      chk("rexec_cnt", res_count, 0);
      tick();
      chk("rexec_stay", res_valid, 0);

      // reset in HOLD, racing a delivery
      cmd_func  = 2'b11;
      cmd_a     = 4'hA;
      cmd_b     = 4'h5;
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      tick();
      chk("rhold_pre_vld", res_valid, 1);
      chk("rhold_pre_data", res_data, 8'hA5);
      Reset_b   = 1'b0;
      res_ready = 1'b1;
      tick();
      Reset_b   = 1'b1;
      res_ready = 1'b0;
      chk("rhold_rdy", cmd_ready, 1);
      chk("rhold_vld", res_valid, 0);
      chk("rhold_data", res_data, 0);
      chk("rhold_cnt", res_count, 0);

      // counter wrap after 16 deliveries
      do_reset();
      for (int i = 0; i < 16; i++)
         op(2'b00, 4'(i), 4'h1, 1'b0, 0, 1'b0, 8'(i + 1),
            $sformatf("wrap%0d", i));
      chk("wrap_zero", res_count, 0);

      // accumulator feedback
      do_reset();
      op(2'b00, 4'h3, 4'h4, 1'b0, 0, 1'b0, 8'h07, "fb_first");
`ifdef ALU_ISSUER_FEEDBACK_EN
      op(2'b00, 4'h1, 4'hF, 1'b1, 0, 1'b0, 8'h08, "fb_second");
`else
      op(2'b00, 4'h1, 4'hF, 1'b1, 0, 1'b0, 8'h10, "fb_second");
`endif

      // random commands against the model
      for (int n = 0; n < 150; n++) begin
         logic [1:0] rf;
         logic [3:0] ra, rb;
         logic       racc;
         rf   = 2'($urandom);
         ra   = 4'($urandom);
         rb   = 4'($urandom);
         racc = 1'($urandom);
         eb   = rb;
`ifdef ALU_ISSUER_FEEDBACK_EN
         if (racc)
            eb = acc_model % 16;
`endif
         e = 8'(ref_res(rf, ra, eb));
         op(rf, ra, rb, racc, $urandom_range(0, 3), 1'($urandom), e,
            $sformatf("rnd%0d", n));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
